// File: rtl/exp_golomb_k_decoder.sv
// Serial Exp-Golomb order-k decoder.
// A codeword is consumed one bit per accepted cycle, MSB first. The decoded
// value and the codeword length are presented on a valid/ready output port.
// Build option: define EXP_GOLOMB_SIGNED_EN to emit the signed mapping se(v)
// instead of the unsigned codeNum. Length and timing are the same either way.
module exp_golomb_k_decoder #(
  parameter int DATA_WIDTH = 16,
  parameter int K_ORDER    = 0
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              dft_tm_i,
  input  logic                              dt_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  output logic [DATA_WIDTH-1:0]             dt_o,
  output logic [$clog2(2*DATA_WIDTH):0]     len_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              err_o
);

  // Counter width matches the length port; it covers both the zero count
  // and the full codeword length 2N+k+1.
  localparam int CW = $clog2(2*DATA_WIDTH) + 1;

  // Largest prefix zero count that still yields a value fitting DATA_WIDTH.
  localparam logic [CW-1:0]         Z_MAX = CW'(DATA_WIDTH - 1 - K_ORDER);
  localparam logic [CW-1:0]         K_C   = CW'(K_ORDER);
  localparam logic [DATA_WIDTH:0]   ONE_B = {{DATA_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH:0]   K_POW = ONE_B << K_ORDER;

  typedef enum logic [1:0] {
    S_PREFIX = 2'd0,
    S_SUFFIX = 2'd1,
    S_OUT    = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t                 state_reg;
  logic [CW-1:0]          zcnt_reg;
  logic [CW-1:0]          scnt_reg;
  logic [DATA_WIDTH:0]    b_reg;

  logic                   rst_int_n;
  logic [DATA_WIDTH:0]    b_shift;
  logic [DATA_WIDTH:0]    b_fin;
  logic [DATA_WIDTH-1:0]  code_num;
  logic [DATA_WIDTH-1:0]  dt_val;
  logic [CW-1:0]          len_calc;
  logic                   accept;
  logic                   no_suffix;
  logic                   last_suffix;

  // Test mode forces the internal reset inactive regardless of rstn_i.
  assign rst_int_n = rstn_i | dft_tm_i;

  // Bits are taken only while gathering prefix or suffix, never in reset.
  assign ready_o = rst_int_n && ((state_reg == S_PREFIX) || (state_reg == S_SUFFIX));
  assign accept  = valid_i && ready_o;

  // Value and length of the codeword completing on the current accepted bit.
  always_comb begin
    b_shift     = (b_reg << 1) | {{DATA_WIDTH{1'b0}}, dt_i};
    b_fin       = (state_reg == S_PREFIX) ? ONE_B : b_shift;
    code_num    = DATA_WIDTH'(b_fin - K_POW);
`ifdef EXP_GOLOMB_SIGNED_EN
    // Odd codeNum maps to a positive value, even to a negative one.
    if (code_num[0]) begin
      dt_val = (code_num + DATA_WIDTH'(1)) >> 1;
    end else begin
      dt_val = -(code_num >> 1);
    end
`else
    dt_val = code_num;
`endif
    len_calc    = (zcnt_reg << 1) + K_C + CW'(1);
    no_suffix   = ((zcnt_reg + K_C) == '0);
    last_suffix = ((scnt_reg + CW'(1)) == (zcnt_reg + K_C));
  end

  // Decoder FSM with registered result, valid and error outputs.
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg <= S_PREFIX;
      zcnt_reg  <= '0;
      scnt_reg  <= '0;
      b_reg     <= '0;
      dt_o      <= '0;
      len_o     <= '0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state_reg)
        S_PREFIX: begin
          if (accept) begin
            if (!dt_i) begin
              if (zcnt_reg == Z_MAX) begin
                // Prefix too long for DATA_WIDTH: drop the codeword.
                state_reg <= S_ERR;
                err_o     <= 1'b1;
                zcnt_reg  <= '0;
                scnt_reg  <= '0;
                b_reg     <= '0;
              end else begin
                zcnt_reg <= zcnt_reg + CW'(1);
              end
            end else begin
              b_reg    <= ONE_B;
              scnt_reg <= '0;
              if (no_suffix) begin
                dt_o      <= dt_val;
                len_o     <= len_calc;
                valid_o   <= 1'b1;
                state_reg <= S_OUT;
              end else begin
                state_reg <= S_SUFFIX;
              end
            end
          end
        end
        S_SUFFIX: begin
          if (accept) begin
            b_reg    <= b_shift;
            scnt_reg <= scnt_reg + CW'(1);
            if (last_suffix) begin
              dt_o      <= dt_val;
              len_o     <= len_calc;
              valid_o   <= 1'b1;
              state_reg <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (ready_i) begin
            valid_o   <= 1'b0;
            zcnt_reg  <= '0;
            scnt_reg  <= '0;
            b_reg     <= '0;
            state_reg <= S_PREFIX;
          end
        end
        default: begin
          zcnt_reg  <= '0;
          scnt_reg  <= '0;
          b_reg     <= '0;
          state_reg <= S_PREFIX;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_golomb_k_decoder.sv
// Scoreboard bench for exp_golomb_k_decoder: one K=0 and one K=2 instance,
// both 8 bits wide. Expected results are queued as codewords are driven and
// retired when the decoder presents a result or an error pulse.
module tb_exp_golomb_k_decoder;

  localparam int W  = 8;
  localparam int LW = $clog2(2*W) + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dft = 1'b0;

  logic d0 = 1'b0, v0 = 1'b0, ri0 = 1'b1;
  logic d1 = 1'b0, v1 = 1'b0;
  logic ri1, ri1_rnd = 1'b1, bp_en = 1'b0;
  logic ro0, vo0, err0, ro1, vo1, err1;
  logic [W-1:0]  dto0, dto1;
  logic [LW-1:0] leno0, leno1;

  assign ri1 = bp_en ? ri1_rnd : 1'b1;

  typedef struct {
    bit          is_err;
    logic [31:0] dt;
    logic [31:0] len;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  exp_golomb_k_decoder #(.DATA_WIDTH(W), .K_ORDER(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .dft_tm_i(dft), .dt_i(d0), .valid_i(v0),
    .ready_o(ro0), .dt_o(dto0), .len_o(leno0), .valid_o(vo0),
    .ready_i(ri0), .err_o(err0)
  );

  exp_golomb_k_decoder #(.DATA_WIDTH(W), .K_ORDER(2)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .dft_tm_i(dft), .dt_i(d1), .valid_i(v1),
    .ready_o(ro1), .dt_o(dto1), .len_o(leno1), .valid_o(vo1),
    .ready_i(ri1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output mapping applied to the unsigned codeNum.
  function automatic logic [31:0] exp_val(input int code);
    logic [W-1:0] r;
`ifdef EXP_GOLOMB_SIGNED_EN
    if (code % 2 == 1) r = W'((code + 1) / 2);
    else               r = W'(-(code / 2));
`else
    r = W'(code);
`endif
    return {24'd0, r};
  endfunction

  task automatic push(input int sel, input int code, input int len);
    exp_t e;
    e.is_err = 1'b0;
    e.dt     = exp_val(code);
    e.len    = len;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic push_err(input int sel);
    exp_t e;
    e.is_err = 1'b1;
    e.dt     = '0;
    e.len    = '0;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Retire one scoreboard entry per result transfer or error pulse.
  task automatic mon(input int sel, input logic vo, input logic ri, input logic er,
                     input logic [W-1:0] dt, input logic [LW-1:0] len);
    exp_t e;
    int   sz;
    sz = (sel == 0) ? q0.size() : q1.size();
    if (er) begin
      if (sz == 0) chk($sformatf("unexpected_err%0d", sel), 32'd1, 32'd0);
      else begin
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        sz--;
        chk($sformatf("err_kind%0d", sel), {31'd0, e.is_err}, 32'd1);
      end
    end
    if (vo && ri) begin
      if (sz == 0) chk($sformatf("unexpected_valid%0d", sel), 32'd1, 32'd0);
      else begin
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("out_kind%0d", sel), {31'd0, e.is_err}, 32'd0);
        chk($sformatf("dt%0d", sel), {24'd0, dt}, e.dt);
        chk($sformatf("len%0d", sel), {27'd0, len}, e.len);
        $display("dut%0d result dt=%0h len=%0d", sel, dt, len);
      end
    end
  endtask

  // Outputs are sampled on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    mon(0, vo0, ri0, err0, dto0, leno0);
    mon(1, vo1, ri1, err1, dto1, leno1);
  end

  // Random downstream backpressure on the K=2 instance when enabled.
  always @(posedge clk) begin
    #1 ri1_rnd = ($urandom_range(0, 3) != 0);
  end

  // Present one bit and hold it until a rising edge accepts it.
  task automatic send_bit(input int sel, input logic b);
    int guard = 0;
    if (sel == 0) begin d0 = b; v0 = 1'b1; end
    else          begin d1 = b; v1 = 1'b1; end
    @(negedge clk);
    while (!((sel == 0) ? ro0 : ro1) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) chk($sformatf("ready_timeout%0d", sel), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if ($urandom_range(0, 3) == 0) begin
      if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cw(input int sel, input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(sel, bits[i]);
    if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sel, k, maxc, code, v, nb, nz;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, vo0}, 32'd0);
    chk("rst_err",   {31'd0, err0}, 32'd0);
    chk("rst_dt",    {24'd0, dto0}, 32'd0);
    chk("rst_len",   {27'd0, leno0}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready0", {31'd0, ro0}, 32'd1);
    chk("rst_ready1", {31'd0, ro1}, 32'd1);
    @(posedge clk);
    #1;

    // K=0 basic codewords 1 / 010 / 00111.
    push(0, 0, 1); send_cw(0, 64'b1, 1);
    push(0, 1, 3); send_cw(0, 64'b010, 3);
    push(0, 6, 5); send_cw(0, 64'b00111, 5);
    wait_drain();

    // K=2 codewords 101 / 01000.
    push(1, 1, 3); send_cw(1, 64'b101, 3);
    push(1, 4, 5); send_cw(1, 64'b01000, 5);
    wait_drain();

    // Signed-mapping examples 00100 / 00101 on K=0.
    push(0, 3, 5); send_cw(0, 64'b00100, 5);
    push(0, 4, 5); send_cw(0, 64'b00101, 5);
    wait_drain();

    // Prefix overflow: eight zeros on K=0, then a lone 1.
    push_err(0);
    for (int i = 0; i < 7; i++) send_bit(0, 1'b0);
    d0 = 1'b0; v0 = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    chk("err_pulse", {31'd0, err0}, 32'd1);
    chk("err_no_valid", {31'd0, vo0}, 32'd0);
    chk("err_ready", {31'd0, ro0}, 32'd0);
    @(posedge clk);
    #1;
    chk("err_one_cycle", {31'd0, err0}, 32'd0);
    push(0, 0, 1); send_cw(0, 64'b1, 1);
    wait_drain();

    // Held result under downstream backpressure.
    ri0 = 1'b0;
    push(0, 1, 3); send_cw(0, 64'b010, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, vo0}, 32'd1);
      chk("bp_dt",    {24'd0, dto0}, exp_val(1));
      chk("bp_len",   {27'd0, leno0}, 32'd3);
      chk("bp_ready", {31'd0, ro0}, 32'd0);
    end
    @(posedge clk);
    #1;
    ri0 = 1'b1;
    wait_drain();

    // Random codewords from an encoder model, backpressure on K=2.
    bp_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      sel  = i % 2;
      k    = (sel == 0) ? 0 : 2;
      maxc = (1 << W) - 1 - (1 << k);
      code = (i < 2) ? maxc : $urandom_range(0, maxc);
      v    = code + (1 << k);
      nb   = 0;
      for (int j = 0; j <= W; j++) if ((v >> j) != 0) nb = j + 1;
      nz   = nb - 1 - k;
      push(sel, code, 2 * nz + k + 1);
      send_cw(sel, 64'(v), 2 * nz + k + 1);
    end
    wait_drain();
    bp_en = 1'b0;

    // Reset mid-codeword discards the partial decode.
    send_cw(0, 64'b0010, 4);
    rstn = 1'b0;
    #1;
    chk("mid_rst_dt",    {24'd0, dto0}, 32'd0);
    chk("mid_rst_len",   {27'd0, leno0}, 32'd0);
    chk("mid_rst_valid", {31'd0, vo0}, 32'd0);
    chk("mid_rst_err",   {31'd0, err0}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ro0}, 32'd1);
    @(posedge clk);
    #1;

    // Test mode overrides a held reset.
    dft  = 1'b1;
    rstn = 1'b0;
    push(0, 6, 5); send_cw(0, 64'b00111, 5);
    wait_drain();
    chk("dft_dt_hold", {24'd0, dto0}, exp_val(6));
    rstn = 1'b1;
    dft  = 1'b0;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
